// File: rtl/fetch_stage.sv
// Fetch stage: drives the icache with the current PC and fills the IF/ID
// latch. A HOLD state parks an instruction that arrived during a stall so it
// is neither lost nor fetched twice. A retired HALT freezes the stage until reset.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        PCStall,
  input  logic        fetch_stall,
  input  logic        fetch_flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        valid_out,
  output logic        halted
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic [31:0] ifid_instr, ifid_instr_n;
  logic [31:0] ifid_npc, ifid_npc_n;
  logic        ifid_valid, ifid_valid_n;
  logic        stall;
  logic [31:0] pc_plus4;

  assign stall    = PCStall | fetch_stall;
  assign pc_plus4 = pc + 32'd4;

  // Next-state decision; the order of the if-chain encodes the priority
  // halt > redirect > flush > stall > ihit (reset is applied in the register block).
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    hold_instr_n = hold_instr;
    ifid_instr_n = ifid_instr;
    ifid_npc_n   = ifid_npc;
    ifid_valid_n = ifid_valid;
    if (state == HALTED) begin
      state_n = HALTED;
    end else if (halt) begin
      state_n      = HALTED;
      ifid_instr_n = 32'd0;
      ifid_npc_n   = 32'd0;
      ifid_valid_n = 1'b0;
    end else if (redirect) begin
      state_n      = FETCH;
      pc_n         = redirect_pc;
      hold_instr_n = 32'd0;
      ifid_instr_n = 32'd0;
      ifid_npc_n   = 32'd0;
      ifid_valid_n = 1'b0;
    end else if (fetch_flush) begin
      ifid_instr_n = 32'd0;
      ifid_npc_n   = 32'd0;
      ifid_valid_n = 1'b0;
    end else if (state == HOLD) begin
      if (!stall) begin
        state_n      = FETCH;
        pc_n         = pc_plus4;
        ifid_instr_n = hold_instr;
        ifid_npc_n   = pc_plus4;
        ifid_valid_n = 1'b1;
      end
    end else begin
      if (ihit) begin
        if (stall) begin
          state_n      = HOLD;
          hold_instr_n = imemload;
        end else begin
          pc_n         = pc_plus4;
          ifid_instr_n = imemload;
          ifid_npc_n   = pc_plus4;
          ifid_valid_n = 1'b1;
        end
      end else if (!stall) begin
        ifid_instr_n = 32'd0;
        ifid_npc_n   = 32'd0;
        ifid_valid_n = 1'b0;
      end
    end
  end

  // State and pipeline registers with synchronous reset overriding everything.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state      <= FETCH;
      pc         <= PC_INIT;
      hold_instr <= 32'd0;
      ifid_instr <= 32'd0;
      ifid_npc   <= 32'd0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      hold_instr <= hold_instr_n;
      ifid_instr <= ifid_instr_n;
      ifid_npc   <= ifid_npc_n;
      ifid_valid <= ifid_valid_n;
    end
  end

  assign imemaddr  = pc;
  assign imemREN   = (state == FETCH);
  assign halted    = (state == HALTED);
  assign instr_out = halted ? 32'd0 : ifid_instr;
  assign valid_out = halted ? 1'b0 : ifid_valid;
  assign npc_out   = ifid_npc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage, plus a short sequence on a
// second instance with a non-zero reset PC.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST, ihit, PCStall, fetch_stall, fetch_flush, redirect, halt;
  logic [31:0] imemload, redirect_pc;
  logic        imemREN, valid_out, halted;
  logic [31:0] imemaddr, instr_out, npc_out;
  logic        imemREN2, valid_out2, halted2;
  logic [31:0] imemaddr2, instr_out2, npc_out2;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        rst;
    logic        hit;
    logic [31:0] load;
    logic        pcs;
    logic        fs;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        hlt;
    logic [31:0] e_addr;
    logic        e_ren;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  vec_t vecs[$];

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .PCStall(PCStall),
    .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_out(instr_out), .npc_out(npc_out), .valid_out(valid_out),
    .halted(halted)
  );

  fetch_stage #(.PC_INIT(32'h00001000)) dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN2), .imemaddr(imemaddr2), .PCStall(PCStall),
    .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_out(instr_out2), .npc_out(npc_out2), .valid_out(valid_out2),
    .halted(halted2)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic rst, hit, input logic [31:0] load,
                              input logic pcs, fs, flush, redir,
                              input logic [31:0] rpc, input logic hlt,
                              input logic [31:0] e_addr, input logic e_ren,
                              input logic [31:0] e_instr, e_npc,
                              input logic e_valid, e_halted);
    vec_t v;
    v.rst = rst; v.hit = hit; v.load = load; v.pcs = pcs; v.fs = fs;
    v.flush = flush; v.redir = redir; v.rpc = rpc; v.hlt = hlt;
    v.e_addr = e_addr; v.e_ren = e_ren; v.e_instr = e_instr;
    v.e_npc = e_npc; v.e_valid = e_valid; v.e_halted = e_halted;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    nRST = v.rst; ihit = v.hit; imemload = v.load; PCStall = v.pcs;
    fetch_stall = v.fs; fetch_flush = v.flush; redirect = v.redir;
    redirect_pc = v.rpc; halt = v.hlt;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b1; ihit = 1'b0; imemload = 32'd0; PCStall = 1'b0;
    fetch_stall = 1'b0; fetch_flush = 1'b0; redirect = 1'b0;
    redirect_pc = 32'd0; halt = 1'b0;

    //           rst hit load          pcs fs fl rd rpc           h   addr          ren instr         npc           v  hd
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'hAAAA0001, 0, 0, 0, 0, 32'h0,        0, 32'h4,        1, 32'hAAAA0001, 32'h4,        1, 0));
    vecs.push_back(mk(0, 1, 32'hBBBB0002, 0, 0, 0, 0, 32'h0,        0, 32'h8,        1, 32'hBBBB0002, 32'h8,        1, 0));
    vecs.push_back(mk(0, 1, 32'hCCCC0003, 0, 0, 0, 0, 32'h0,        0, 32'hC,        1, 32'hCCCC0003, 32'hC,        1, 0));
    vecs.push_back(mk(1, 1, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'hDDDD0004, 0, 0, 0, 0, 32'h0,        0, 32'h4,        1, 32'hDDDD0004, 32'h4,        1, 0));
    vecs.push_back(mk(0, 1, 32'hEEEE0005, 0, 0, 0, 0, 32'h0,        0, 32'h8,        1, 32'hEEEE0005, 32'h8,        1, 0));
    // stall three cycles with the instruction at PC 8 parked
    vecs.push_back(mk(0, 1, 32'hF00D0008, 1, 0, 0, 0, 32'h0,        0, 32'h8,        0, 32'hEEEE0005, 32'h8,        1, 0));
    vecs.push_back(mk(0, 1, 32'hBAD00000, 0, 1, 0, 0, 32'h0,        0, 32'h8,        0, 32'hEEEE0005, 32'h8,        1, 0));
    vecs.push_back(mk(0, 1, 32'hBAD00001, 1, 0, 0, 0, 32'h0,        0, 32'h8,        0, 32'hEEEE0005, 32'h8,        1, 0));
    vecs.push_back(mk(0, 1, 32'hBAD00002, 0, 0, 0, 0, 32'h0,        0, 32'hC,        1, 32'hF00D0008, 32'hC,        1, 0));
    vecs.push_back(mk(0, 1, 32'h6666000C, 0, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h6666000C, 32'h10,       1, 0));
    // miss with stall holds, miss without stall bubbles
    vecs.push_back(mk(0, 0, 32'hBAD00003, 1, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h6666000C, 32'h10,       1, 0));
    vecs.push_back(mk(0, 0, 32'hBAD00004, 0, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h0,        32'h0,        0, 0));
    // park at 0x10, then redirect to 0x40 while still stalled
    vecs.push_back(mk(0, 1, 32'h11110010, 1, 0, 0, 0, 32'h0,        0, 32'h10,       0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'hBAD00005, 1, 0, 0, 1, 32'h40,       0, 32'h40,       1, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'h22220040, 0, 0, 0, 0, 32'h0,        0, 32'h44,       1, 32'h22220040, 32'h44,       1, 0));
    // flush in FETCH drops the hit and keeps the PC
    vecs.push_back(mk(0, 1, 32'hBAD00006, 0, 0, 1, 0, 32'h0,        0, 32'h44,       1, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'h33330044, 0, 0, 0, 0, 32'h0,        0, 32'h48,       1, 32'h33330044, 32'h48,       1, 0));
    // flush in HOLD bubbles IF/ID but keeps the parked instruction
    vecs.push_back(mk(0, 1, 32'h44440048, 1, 0, 0, 0, 32'h0,        0, 32'h48,       0, 32'h33330044, 32'h48,       1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        0, 32'h48,       0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'hBAD00007, 0, 0, 0, 0, 32'h0,        0, 32'h4C,       1, 32'h44440048, 32'h4C,       1, 0));
    // redirect beats stall
    vecs.push_back(mk(0, 1, 32'hBAD00008, 1, 1, 0, 1, 32'h80,       0, 32'h80,       1, 32'h0,        32'h0,        0, 0));
    // wrap-around of PC+4
    vecs.push_back(mk(0, 1, 32'hBAD00009, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 1, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'h5555FFFC, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h5555FFFC, 32'h0,        1, 0));
    // halt beats redirect, then stays halted whatever arrives
    vecs.push_back(mk(0, 1, 32'hBAD0000A, 0, 0, 0, 1, 32'h200,      1, 32'h0,        0, 32'h0,        32'h0,        0, 1));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 1, 32'hBAD10000 + i, i[0], 0, i[1], i[0], 32'h100, 0,
                        32'h0, 0, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 1, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'h77770000, 0, 0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h77770000, 32'h4,        1, 0));
    // reset in the middle of HOLD
    vecs.push_back(mk(0, 1, 32'h88880004, 1, 0, 0, 0, 32'h0,        0, 32'h4,        0, 32'h77770000, 32'h4,        1, 0));
    vecs.push_back(mk(1, 1, 32'hBAD0000B, 1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'h99990000, 0, 0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h99990000, 32'h4,        1, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d imemaddr", i), imemaddr, vecs[i].e_addr);
      checkOutput($sformatf("v%0d imemREN", i), {31'd0, imemREN}, {31'd0, vecs[i].e_ren});
      checkOutput($sformatf("v%0d instr_out", i), instr_out, vecs[i].e_instr);
      checkOutput($sformatf("v%0d npc_out", i), npc_out, vecs[i].e_npc);
      checkOutput($sformatf("v%0d valid_out", i), {31'd0, valid_out}, {31'd0, vecs[i].e_valid});
      checkOutput($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
    end

    // Second instance: reset PC comes from the parameter.
    applyStimulus(mk(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
    checkOutput("pcinit imemaddr", imemaddr2, 32'h00001000);
    checkOutput("pcinit imemREN", {31'd0, imemREN2}, 32'd1);
    applyStimulus(mk(0, 1, 32'hABCD1234, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
    checkOutput("pcinit instr_out", instr_out2, 32'hABCD1234);
    checkOutput("pcinit npc_out", npc_out2, 32'h00001004);
    checkOutput("pcinit valid_out", {31'd0, valid_out2}, 32'd1);
    checkOutput("pcinit advance", imemaddr2, 32'h00001004);
    applyStimulus(mk(0, 1, 32'h0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0, 0, 0));
    checkOutput("pcinit halted", {31'd0, halted2}, 32'd1);
    checkOutput("pcinit halt pc", imemaddr2, 32'h00001004);
    applyStimulus(mk(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
    checkOutput("pcinit rehalt reset", imemaddr2, 32'h00001000);
    checkOutput("pcinit rehalt halted", {31'd0, halted2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
